time_entry_loader: RTL and testbench
====================================

// Module: time_entry_loader
// PURPOSE
//  Keypad-side writer for the microwave MM:SS down-counter chain. Shifts BCD digits
//  in from the right (microwave style), validates the value, and drives the counter
//  chain's parallel-load bus (4 digits + active-low loadn). Locks entry while the
//  timer runs; releases when the chain reports zero. Clear aborts and loads 00:00.
// PARAMETERS
//  SEC_TENS_MAX   5     largest legal seconds-tens digit (mod-6 counter range)
//  MIN_TENS_MAX   9     largest legal minutes-tens digit
//  ENTRY_TIMEOUT  1000  idle cycles in ENTRY before auto-clear; 0 disables
// PORTS
//  clk          in   1  clock, all state on rising edge
//  clrn         in   1  asynchronous, active-low reset
//  key_valid    in   1  one-cycle strobe, key_code valid
//  key_code     in   4  BCD digit 0..9; 10..15 illegal
//  start        in   1  one-cycle strobe, commit entered time to timer
//  clear_key    in   1  one-cycle strobe, clear entry / abort running timer
//  timer_zero   in   1  counter chain reached 00:00 (level)
//  sec_ones     out  4  load data, seconds ones
//  sec_tens     out  4  load data, seconds tens
//  min_ones     out  4  load data, minutes ones
//  min_tens     out  4  load data, minutes tens
//  loadn        out  1  active-low parallel-load strobe to counter chain
//  ready        out  1  ENTRY state, value nonzero and legal
//  busy         out  1  state is LOAD or LOCKED
//  digit_count  out  3  digits entered, 0..4
//  err          out  1  one-cycle pulse on rejected key/start
// BEHAVIOUR
//  Reset: state IDLE; all digits 0; digit_count 0; loadn 1; ready/busy/err 0;
//    timeout counter 0. Reset mid-operation returns to IDLE immediately (async).
//  States: IDLE, ENTRY, LOAD, LOCKED, ABORT. All outputs registered.
//  Priority per cycle: clear_key > start > key_valid. Lower events dropped, no err.
//  Key (IDLE/ENTRY), key_code<=9, digit_count<4:
//    {min_tens,min_ones,sec_tens,sec_ones} <= {min_ones,sec_tens,sec_ones,key_code};
//    digit_count+1; state -> ENTRY; timeout counter cleared.
//  Key with code>9, or digit_count==4: no change, err=1 next cycle.
//  Keys in LOAD/LOCKED/ABORT: silently ignored.
//  Legal value: sec_tens<=SEC_TENS_MAX, min_tens<=MIN_TENS_MAX, not all digits 0.
//  start in ENTRY with legal value: -> LOAD; loadn=0 exactly 1 cycle (cycle after
//    start); digits stable that cycle and held through LOCKED. Then -> LOCKED.
//  start in ENTRY with illegal value, or in IDLE: err pulse, state unchanged.
//  start in LOAD/LOCKED/ABORT: ignored.
//  LOCKED: on timer_zero=1 -> IDLE; digits and digit_count cleared. timer_zero
//    ignored in all other states (incl. LOAD cycle itself).
//  clear_key in IDLE/ENTRY: digits, digit_count -> 0, state IDLE, no loadn.
//  clear_key in LOCKED: digits -> 0, -> ABORT; loadn=0 one cycle with data 0000
//    (zeroes chain), then IDLE. clear_key in LOAD: honoured next cycle (as LOCKED).
//  Timeout: ENTRY_TIMEOUT>0, ENTRY, no key for ENTRY_TIMEOUT consecutive cycles:
//    same as clear_key in ENTRY. Counter width $clog2(ENTRY_TIMEOUT+1), saturating.
//  ready is combinational-free (registered from next-state value); busy likewise.
//  loadn never low two consecutive cycles; never low outside LOAD/ABORT.
// TESTING
//  Keys 1,3,0 then start -> digits 0,1,3,0; loadn low 1 cycle; busy=1; count=3.
//  Keys 1,7,5 (sec_tens=7) then start -> err pulse, loadn stays 1, state ENTRY.
//  Keys 1,2,3,4,5 -> 5th key err pulse; value stays 12:34; digit_count=4.
//  Load 00:10, raise timer_zero in LOCKED -> IDLE, digits 0, busy=0, keys accepted.
//  LOCKED + clear_key -> next cycle loadn=0 with data 0000, then IDLE; start+key
//    same cycle in ENTRY -> start wins, key dropped.
//  ENTRY_TIMEOUT=8: key 5, wait 8 idle cycles -> digits 0, digit_count 0, IDLE;
//    assert clrn low mid-LOAD -> loadn=1, IDLE immediately.

Source files
------------

// File: rtl/time_entry_loader.sv
// Keypad-side writer for the microwave MM:SS down-counter chain: shifts BCD digits
// in from the right, validates the value and drives the chain's parallel-load bus.
module time_entry_loader #(
  parameter int SEC_TENS_MAX  = 5,
  parameter int MIN_TENS_MAX  = 9,
  parameter int ENTRY_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       clear_key,
  input  logic       timer_zero,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       loadn,
  output logic       ready,
  output logic       busy,
  output logic [2:0] digit_count,
  output logic       err
);

  localparam int TW = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(ENTRY_TIMEOUT);
  localparam logic [3:0] STMAX = 4'(SEC_TENS_MAX);
  localparam logic [3:0] MTMAX = 4'(MIN_TENS_MAX);

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, LOCKED, ABORT} state_t;

  state_t        state, nstate;
  logic [15:0]   digits, ndigits;
  logic [2:0]    cnt, ncnt;
  logic [TW-1:0] tmo, ntmo, tmo_inc;
  logic          pend, npend;
  logic          nloadn, nerr, nready, nbusy;
  logic          key_ok, timeout_hit;

  // digits packs {min_tens, min_ones, sec_tens, sec_ones}
  function automatic logic legal(input logic [15:0] v);
    return (v[7:4] <= STMAX) && (v[15:12] <= MTMAX) && (v != 16'h0000);
  endfunction

  assign key_ok      = (key_code <= 4'd9) && (cnt < 3'd4);
  assign tmo_inc     = (tmo == TMAX) ? tmo : tmo + 1'b1;
  assign timeout_hit = (ENTRY_TIMEOUT > 0) && (tmo_inc == TMAX);

  always_comb begin
    nstate  = state;
    ndigits = digits;
    ncnt    = cnt;
    npend   = pend;
    nloadn  = 1'b1;
    nerr    = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (clear_key) begin
          ndigits = 16'h0000;
          ncnt    = 3'd0;
          nstate  = IDLE;
        end else if (start) begin
          if (state == ENTRY && legal(digits)) begin
            nstate = LOAD;
            nloadn = 1'b0;
          end else begin
            nerr = 1'b1;
          end
        end else if (key_valid) begin
          if (key_ok) begin
            ndigits = {digits[11:0], key_code};
            ncnt    = cnt + 3'd1;
            nstate  = ENTRY;
          end else begin
            nerr = 1'b1;
          end
        end else if (state == ENTRY && timeout_hit) begin
          ndigits = 16'h0000;
          ncnt    = 3'd0;
          nstate  = IDLE;
        end
      end
      LOAD: begin
        // a clear during the load strobe is deferred so loadn never stays low twice
        nstate = LOCKED;
        if (clear_key) npend = 1'b1;
      end
      LOCKED: begin
        if (clear_key || pend) begin
          ndigits = 16'h0000;
          ncnt    = 3'd0;
          npend   = 1'b0;
          nloadn  = 1'b0;
          nstate  = ABORT;
        end else if (timer_zero) begin
          ndigits = 16'h0000;
          ncnt    = 3'd0;
          nstate  = IDLE;
        end
      end
      ABORT:   nstate = IDLE;
      default: nstate = IDLE;
    endcase

    if (nstate != ENTRY || key_valid) ntmo = '0;
    else                              ntmo = tmo_inc;

    nready = (nstate == ENTRY) && legal(ndigits);
    nbusy  = (nstate == LOAD) || (nstate == LOCKED);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      digits <= 16'h0000;
      cnt    <= 3'd0;
      tmo    <= '0;
      pend   <= 1'b0;
      loadn  <= 1'b1;
      ready  <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= nstate;
      digits <= ndigits;
      cnt    <= ncnt;
      tmo    <= ntmo;
      pend   <= npend;
      loadn  <= nloadn;
      ready  <= nready;
      busy   <= nbusy;
      err    <= nerr;
    end
  end

  assign min_tens    = digits[15:12];
  assign min_ones    = digits[11:8];
  assign sec_tens    = digits[7:4];
  assign sec_ones    = digits[3:0];
  assign digit_count = cnt;

endmodule

// File: tb/tb_time_entry_loader.sv
// Self-checking bench for time_entry_loader: decimal-value reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_time_entry_loader;

  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start = 1'b0;
  logic       clear_key = 1'b0;
  logic       timer_zero = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       loadn, ready, busy, err;
  logic [2:0] digit_count;

  int checks = 0;
  int errors = 0;
  bit cmpEn = 1'b0;

  time_entry_loader #(.SEC_TENS_MAX(5), .MIN_TENS_MAX(9), .ENTRY_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .clear_key(clear_key), .timer_zero(timer_zero),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .loadn(loadn), .ready(ready), .busy(busy), .digit_count(digit_count), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: the entered time as a decimal number MMSS
  localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_LOCKED = 3, M_ABORT = 4;
  int mVal = 0, mCnt = 0, mMode = M_IDLE, mTmo = 0;
  bit mPend = 0;
  bit eLoadn = 1, eErr = 0, eReady = 0, eBusy = 0;

  function automatic bit legalVal(input int v);
    return ((v / 10) % 10) <= 5 && (v / 1000) <= 9 && v != 0;
  endfunction

  function automatic int toBcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int satInc(input int t);
    return (t + 1 > TIMEOUT) ? TIMEOUT : t + 1;
  endfunction

  initial forever begin
    @(posedge clk or negedge clrn);
    if (!clrn) begin
      mVal = 0; mCnt = 0; mMode = M_IDLE; mTmo = 0; mPend = 0;
      eLoadn = 1; eErr = 0; eReady = 0; eBusy = 0;
    end else begin
      eErr = 0;
      eLoadn = 1;
      if (mMode == M_IDLE || mMode == M_ENTRY) begin
        if (clear_key) begin
          mVal = 0; mCnt = 0; mMode = M_IDLE; mTmo = 0;
        end else if (start) begin
          if (mMode == M_ENTRY && legalVal(mVal)) begin
            mMode = M_LOAD; eLoadn = 0; mTmo = 0;
          end else begin
            eErr = 1;
            mTmo = (mMode == M_ENTRY && !key_valid) ? satInc(mTmo) : 0;
          end
        end else if (key_valid) begin
          if (key_code <= 9 && mCnt < 4) begin
            mVal = (mVal * 10 + int'(key_code)) % 10000;
            mCnt = mCnt + 1;
            mMode = M_ENTRY;
          end else begin
            eErr = 1;
          end
          mTmo = 0;
        end else if (mMode == M_ENTRY) begin
          mTmo = satInc(mTmo);
          if (mTmo >= TIMEOUT) begin
            mVal = 0; mCnt = 0; mMode = M_IDLE; mTmo = 0;
          end
        end
      end else if (mMode == M_LOAD) begin
        if (clear_key) mPend = 1;
        mMode = M_LOCKED;
      end else if (mMode == M_LOCKED) begin
        if (clear_key || mPend) begin
          mVal = 0; mCnt = 0; mPend = 0; eLoadn = 0; mMode = M_ABORT;
        end else if (timer_zero) begin
          mVal = 0; mCnt = 0; mMode = M_IDLE;
        end
      end else begin
        mMode = M_IDLE;
      end
      eReady = (mMode == M_ENTRY) && legalVal(mVal);
      eBusy = (mMode == M_LOAD) || (mMode == M_LOCKED);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (clrn && cmpEn) begin
      checkOutput("model.digits", int'({min_tens, min_ones, sec_tens, sec_ones}), toBcd(mVal));
      checkOutput("model.count", int'(digit_count), mCnt);
      checkOutput("model.loadn", int'(loadn), int'(eLoadn));
      checkOutput("model.err", int'(err), int'(eErr));
      checkOutput("model.ready", int'(ready), int'(eReady));
      checkOutput("model.busy", int'(busy), int'(eBusy));
    end
  end

  // Drive one cycle of strobes; returns just after the capturing rising edge
  task automatic applyStimulus(input bit kv, input int kc, input bit st, input bit clr, input bit tz);
    @(negedge clk);
    key_valid = kv; key_code = 4'(kc); start = st; clear_key = clr; timer_zero = tz;
    @(posedge clk);
    #1;
    key_valid = 0; key_code = 4'd0; start = 0; clear_key = 0; timer_zero = 0;
  endtask

  task automatic pressKey(input int kc);
    applyStimulus(1, kc, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  function automatic int shownDigits();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #2 clrn = 1;
    cmpEn = 1;
    checkOutput("reset.loadn", int'(loadn), 1);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.count", int'(digit_count), 0);
    checkOutput("reset.ready", int'(ready), 0);

    // 01:30 load, then timer_zero releases the lock
    pressKey(1); pressKey(3); pressKey(0);
    checkOutput("t1.ready", int'(ready), 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t1.loadn", int'(loadn), 0);
    checkOutput("t1.digits", shownDigits(), 'h0130);
    checkOutput("t1.busy", int'(busy), 1);
    checkOutput("t1.count", int'(digit_count), 3);
    idle(1);
    checkOutput("t1.loadn_hi", int'(loadn), 1);
    checkOutput("t1.locked_busy", int'(busy), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1.release_busy", int'(busy), 0);
    checkOutput("t1.release_digits", shownDigits(), 0);

    // 01:75 has an illegal seconds-tens digit
    pressKey(1); pressKey(7); pressKey(5);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t2.err", int'(err), 1);
    checkOutput("t2.loadn", int'(loadn), 1);
    checkOutput("t2.ready", int'(ready), 0);
    idle(1);
    checkOutput("t2.err_clear", int'(err), 0);
    applyStimulus(0, 0, 0, 1, 0);

    // fifth digit rejected
    pressKey(1); pressKey(2); pressKey(3); pressKey(4);
    pressKey(5);
    checkOutput("t3.err", int'(err), 1);
    checkOutput("t3.digits", shownDigits(), 'h1234);
    checkOutput("t3.count", int'(digit_count), 4);
    applyStimulus(0, 0, 0, 1, 0);
    pressKey(12);
    checkOutput("t3.illegal_code_err", int'(err), 1);
    checkOutput("t3.illegal_code_count", int'(digit_count), 0);

    // 00:10, timer_zero ignored in LOAD, honoured in LOCKED
    pressKey(1); pressKey(0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4.tz_in_load_ignored", int'(busy), 1);
    idle(2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4.busy", int'(busy), 0);
    checkOutput("t4.digits", shownDigits(), 0);
    pressKey(4);
    checkOutput("t4.key_after", int'(digit_count), 1);
    checkOutput("t4.key_digits", shownDigits(), 'h0004);
    applyStimulus(0, 0, 0, 1, 0);

    // clear while LOCKED zeroes the chain
    pressKey(2); pressKey(5);
    applyStimulus(0, 0, 1, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t5.abort_loadn", int'(loadn), 0);
    checkOutput("t5.abort_digits", shownDigits(), 0);
    checkOutput("t5.abort_busy", int'(busy), 0);
    idle(1);
    checkOutput("t5.idle_loadn", int'(loadn), 1);
    pressKey(7);
    checkOutput("t5.key_after", int'(digit_count), 1);
    applyStimulus(0, 0, 0, 1, 0);

    // start beats a same-cycle key; clear during LOAD is deferred
    pressKey(1); pressKey(2);
    applyStimulus(1, 9, 1, 0, 0);
    checkOutput("t6.loadn", int'(loadn), 0);
    checkOutput("t6.digits", shownDigits(), 'h0012);
    checkOutput("t6.count", int'(digit_count), 2);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t6.locked_loadn", int'(loadn), 1);
    checkOutput("t6.locked_busy", int'(busy), 1);
    idle(1);
    checkOutput("t6.abort_loadn", int'(loadn), 0);
    checkOutput("t6.abort_digits", shownDigits(), 0);
    idle(1);
    checkOutput("t6.idle_loadn", int'(loadn), 1);

    // entry timeout after TIMEOUT idle cycles
    pressKey(5);
    idle(TIMEOUT - 1);
    checkOutput("t7.before_timeout", int'(digit_count), 1);
    idle(1);
    checkOutput("t7.after_timeout_count", int'(digit_count), 0);
    checkOutput("t7.after_timeout_digits", shownDigits(), 0);

    // asynchronous reset during LOAD
    pressKey(4); pressKey(2);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t8.loadn_low", int'(loadn), 0);
    #1 clrn = 0;
    #1;
    checkOutput("t8.reset_loadn", int'(loadn), 1);
    checkOutput("t8.reset_busy", int'(busy), 0);
    checkOutput("t8.reset_count", int'(digit_count), 0);
    @(posedge clk);
    #2 clrn = 1;
    pressKey(3);
    checkOutput("t8.key_after_reset", int'(digit_count), 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
